// File: rtl/pipe_chain_mod.sv
// Elastic valid/ready pipeline with a compile-time mask of register vs pass-through slots.
// Define PIPE_CHAIN_OCC_EN to add the registered occupancy output occ.
module pipe_chain_mod #(
  parameter int unsigned      WIDTH      = 18,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [DEPTH-1:0] STAGE_MASK = {DEPTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d, load;

  // Index k of fwd_* is what slot k sees from upstream; index DEPTH is the block output.
  logic [WIDTH-1:0] fwd_d [DEPTH+1];
  logic [DEPTH:0]   fwd_v;
  // Index k of bwd_r is the ready presented upstream by slot k; index DEPTH is out_ready.
  logic [DEPTH:0]   bwd_r;
  logic             live;

  assign live = rst & en & ~flush;

  always_comb begin
    fwd_v    = '0;
    fwd_v[0] = in_valid;
    for (int unsigned k = 0; k <= DEPTH; k++) begin
      fwd_d[k] = '0;
    end
    fwd_d[0] = in_data;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (STAGE_MASK[k]) begin
        fwd_v[k+1] = valid_q[k];
        fwd_d[k+1] = data_q[k];
      end else begin
        fwd_v[k+1] = fwd_v[k];
        fwd_d[k+1] = fwd_d[k];
      end
    end
  end

  // Ready ripples combinationally from out_ready back to in_ready; no skid buffering.
  always_comb begin
    bwd_r        = '0;
    bwd_r[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (STAGE_MASK[k]) begin
        bwd_r[k] = ~valid_q[k] | bwd_r[k+1];
      end else begin
        bwd_r[k] = bwd_r[k+1];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    load    = '0;
    if (flush) begin
      valid_d = '0;
    end else if (en) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (STAGE_MASK[k]) begin
          if (fwd_v[k] && bwd_r[k]) begin
            load[k]    = 1'b1;
            valid_d[k] = 1'b1;
          end else if (bwd_r[k+1]) begin
            valid_d[k] = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          data_q[k] <= fwd_d[k];
        end
      end
    end
  end

  assign in_ready  = live & bwd_r[0];
  assign out_valid = live & fwd_v[DEPTH];
  // Gated so the output is defined during the first reset cycle, before any edge.
  assign out_data  = rst ? fwd_d[DEPTH] : '0;

`ifdef PIPE_CHAIN_OCC_EN
  localparam int unsigned OccW = $clog2(DEPTH+1);

  logic [OccW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid_d[k]) begin
        occ_d = occ_d + OccW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = rst ? occ_q : '0;
`endif

endmodule

// File: tb/tb_pipe_chain_mod.sv
// Bench for pipe_chain_mod: three instances (masks 1111, 0101, 0000) share stimulus and are
// each checked against a shift-with-bubble-collapse model of N register slots.
module tb_pipe_chain_mod;
  localparam int unsigned W = 18;
  localparam int unsigned D = 4;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic         rst, en, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_ready_w, out_valid_w;
  logic [W-1:0] out_data_w [3];
`ifdef PIPE_CHAIN_OCC_EN
  localparam int unsigned OW = $clog2(D+1);
  logic [OW-1:0] occ_w [3];
  logic [OW-1:0] exp_occ [3], got_occ [3];
`endif

  pipe_chain_mod #(.WIDTH(W), .DEPTH(D), .STAGE_MASK(4'b1111)) u_full (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[0]), .out_data(out_data_w[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready)
`ifdef PIPE_CHAIN_OCC_EN
    , .occ(occ_w[0])
`endif
  );

  pipe_chain_mod #(.WIDTH(W), .DEPTH(D), .STAGE_MASK(4'b0101)) u_half (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[1]), .out_data(out_data_w[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready)
`ifdef PIPE_CHAIN_OCC_EN
    , .occ(occ_w[1])
`endif
  );

  pipe_chain_mod #(.WIDTH(W), .DEPTH(D), .STAGE_MASK(4'b0000)) u_wire (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_w[2]), .out_data(out_data_w[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready)
`ifdef PIPE_CHAIN_OCC_EN
    , .occ(occ_w[2])
`endif
  );

  int           nreg [3] = '{4, 2, 0};
  logic         mv [3][4];
  logic [W-1:0] md [3][4];
  logic         nv [3][4];
  logic [W-1:0] nd [3][4];
  logic [W+1:0] exp_obs [3], got_obs [3];
  logic         acc [3];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;

  // Model: with out_ready every slot shifts forward; otherwise slots up to the highest
  // empty one shift forward and the full tail holds.
  task automatic predict();
    #2;
    for (int m = 0; m < 3; m++) begin
      int           n;
      int           e;
      int           cnt;
      logic         live, ir, ov;
      logic [W-1:0] od;
      n    = nreg[m];
      live = rst && en && !flush;
      e    = -1;
      cnt  = 0;
      for (int k = 0; k < n; k++) begin
        if (!mv[m][k]) e = k;
        else cnt++;
      end
      ir = live && (out_ready || e >= 0);
      if (n == 0) begin
        ov = live && in_valid;
        od = rst ? in_data : '0;
      end else begin
        ov = live && mv[m][n-1];
        od = rst ? md[m][n-1] : '0;
      end
      exp_obs[m] = {ir, ov, od};
      acc[m]     = ir && in_valid;
`ifdef PIPE_CHAIN_OCC_EN
      exp_occ[m] = OW'(cnt);
`endif
      for (int k = 0; k < 4; k++) begin
        nv[m][k] = mv[m][k];
        nd[m][k] = md[m][k];
      end
      if (!rst) begin
        for (int k = 0; k < 4; k++) begin
          nv[m][k] = 1'b0;
          nd[m][k] = '0;
        end
      end else if (flush) begin
        for (int k = 0; k < 4; k++) nv[m][k] = 1'b0;
      end else if (en) begin
        if (out_ready) e = n - 1;
        for (int k = e; k >= 1; k--) begin
          nv[m][k] = mv[m][k-1];
          if (mv[m][k-1]) nd[m][k] = md[m][k-1];
        end
        if (e >= 0) begin
          nv[m][0] = in_valid;
          if (in_valid) nd[m][0] = in_data;
        end
      end
      got_obs[m] = {in_ready_w[m], out_valid_w[m], out_data_w[m]};
`ifdef PIPE_CHAIN_OCC_EN
      got_occ[m] = occ_w[m];
`endif
    end
  endtask

  task automatic advance();
    @(posedge clk);
    mv = nv;
    md = nd;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b1;
      in_data = W'($urandom);
      predict();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (got_obs[m] !== exp_obs[m]) begin
          failures++;
          $display("FAIL reset dut%0d cyc%0d got=%h exp=%h", m, i, got_obs[m], exp_obs[m]);
        end
`ifdef PIPE_CHAIN_OCC_EN
        checks++;
        if (got_occ[m] !== exp_occ[m]) begin
          failures++;
          $display("FAIL reset_occ dut%0d got=%0d exp=%0d", m, got_occ[m], exp_occ[m]);
        end
`endif
      end
      if (i < 3) begin
        checks++;
        if ({in_ready_w, out_valid_w} !== 6'b0) begin
          failures++;
          $display("FAIL reset_hs got=%b exp=000000", {in_ready_w, out_valid_w});
        end
      end else begin
        checks++;
        if (in_ready_w !== 3'b111) begin
          failures++;
          $display("FAIL reset_release_ready got=%b exp=111", in_ready_w);
        end
      end
      advance();
    end
  endtask

  task automatic test_stream();
    int t_acc [3] = '{-1, -1, -1};
    int t_out [3] = '{-1, -1, -1};
    int lat [3]   = '{4, 2, 0};
    rst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      in_valid = (i <= 8);
      in_data  = W'(i);
      predict();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (got_obs[m] !== exp_obs[m]) begin
          failures++;
          $display("FAIL stream dut%0d word%0d got=%h exp=%h", m, i, got_obs[m], exp_obs[m]);
        end
        if (acc[m] && in_data == W'(1) && t_acc[m] < 0) t_acc[m] = cyc;
        if (out_valid_w[m] && out_data_w[m] == W'(1) && t_out[m] < 0) t_out[m] = cyc;
      end
      advance();
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (t_acc[m] < 0 || t_out[m] < 0 || t_out[m] - t_acc[m] != lat[m]) begin
        failures++;
        $display("FAIL latency dut%0d got=%0d exp=%0d", m, t_out[m] - t_acc[m], lat[m]);
      end
    end
  endtask

  task automatic test_backpressure();
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_ready = !(i >= 5 && i != 9);
      in_valid  = (i >= 5);
      in_data   = W'($urandom);
      predict();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (got_obs[m] !== exp_obs[m]) begin
          failures++;
          $display("FAIL backpressure dut%0d cyc%0d got=%h exp=%h", m, i, got_obs[m],
                   exp_obs[m]);
        end
`ifdef PIPE_CHAIN_OCC_EN
        checks++;
        if (got_occ[m] !== exp_occ[m]) begin
          failures++;
          $display("FAIL bp_occ dut%0d got=%0d exp=%0d", m, got_occ[m], exp_occ[m]);
        end
`endif
      end
      if (i >= 10) begin
        checks++;
        if (in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b1) begin
          failures++;
          $display("FAIL full_hold got=%b%b exp=01", in_ready_w[0], out_valid_w[0]);
        end
`ifdef PIPE_CHAIN_OCC_EN
        checks++;
        if (occ_w[0] !== OW'(4)) begin
          failures++;
          $display("FAIL full_occ got=%0d exp=4", occ_w[0]);
        end
`endif
      end
      if (i == 9) begin
        checks++;
        if (in_ready_w[0] !== 1'b1) begin
          failures++;
          $display("FAIL full_pop_ready got=%b exp=1", in_ready_w[0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      flush     = (i == 8);
      out_ready = !(i >= 5 && i < 8);
      in_valid  = (i >= 5 && i <= 8);
      in_data   = (i == 8) ? 18'h3ABCD : (W'($urandom) & 18'h0FFFF);
      predict();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (got_obs[m] !== exp_obs[m]) begin
          failures++;
          $display("FAIL flush dut%0d cyc%0d got=%h exp=%h", m, i, got_obs[m], exp_obs[m]);
        end
`ifdef PIPE_CHAIN_OCC_EN
        checks++;
        if (got_occ[m] !== exp_occ[m]) begin
          failures++;
          $display("FAIL flush_occ dut%0d got=%0d exp=%0d", m, got_occ[m], exp_occ[m]);
        end
`endif
        if (i > 8) begin
          checks++;
          if (out_valid_w[m] === 1'b1 && out_data_w[m] === 18'h3ABCD) begin
            failures++;
            $display("FAIL flushed_word_out dut%0d got=%h exp=none", m, out_data_w[m]);
          end
        end
      end
      if (i == 8 || i == 9) begin
        checks++;
        if (out_valid_w !== 3'b000 || (i == 8 && in_ready_w !== 3'b000)) begin
          failures++;
          $display("FAIL flush_hs cyc%0d got=%b%b exp=000", i, in_ready_w, out_valid_w);
        end
      end
      advance();
    end
  endtask

  task automatic test_enable();
    rst = 1'b1; flush = 1'b0;
    for (int i = 0; i < 18; i++) begin
      en        = !(i >= 3 && i < 8);
      in_valid  = (i < 8) ? 1'b1 : 1'($urandom);
      out_ready = (i < 3) ? 1'b0 : 1'($urandom);
      in_data   = W'($urandom);
      predict();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (got_obs[m] !== exp_obs[m]) begin
          failures++;
          $display("FAIL enable dut%0d cyc%0d got=%h exp=%h", m, i, got_obs[m], exp_obs[m]);
        end
      end
      if (!en) begin
        checks++;
        if ({in_ready_w, out_valid_w} !== 6'b0) begin
          failures++;
          $display("FAIL enable_off_hs got=%b exp=000000", {in_ready_w, out_valid_w});
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 79) != 0);
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = W'($urandom);
      predict();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (got_obs[m] !== exp_obs[m]) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d got=%h exp=%h", m, i, got_obs[m], exp_obs[m]);
        end
`ifdef PIPE_CHAIN_OCC_EN
        checks++;
        if (got_occ[m] !== exp_occ[m]) begin
          failures++;
          $display("FAIL random_occ dut%0d got=%0d exp=%0d", m, got_occ[m], exp_occ[m]);
        end
`endif
      end
      advance();
    end
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 4; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = '0;
      end
    end
    in_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_enable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
